sbox_lookup_pipe: RTL
=====================

// Module: sbox_lookup_pipe
// PURPOSE
//  Parametrised, programmable S-box lookup engine; successor to the fixed S-DES S-boxes used by Fk.
//  Applies one shared table to LANES inputs per beat through a 2-stage valid/ready pipeline.
//  Table resets to the S-DES S1 mapping and is rewritable at run time until locked.
//  Sits between the expansion/key-XOR stage and the P4 permutation of the round datapath.
// PARAMETERS
//  IN_W   4  input bits per lane (>=3); table depth 2^IN_W
//  OUT_W  2  output bits per lane (<=IN_W)
//  LANES  2  parallel lanes sharing one table
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  rst        in   1            synchronous reset, active-high
//  in_valid   in   1            input beat valid
//  in_ready   out  1            engine can accept input beat
//  in_data    in   LANES*IN_W   lane k = in_data[k*IN_W +: IN_W]
//  out_valid  out  1            output beat valid
//  out_ready  in   1            downstream accepts output beat
//  out_data   out  LANES*OUT_W  lane k = out_data[k*OUT_W +: OUT_W]
//  tbl_we     in   1            table write request (single cycle)
//  tbl_addr   in   IN_W         table index {row,col}
//  tbl_wdata  in   OUT_W        entry value
//  tbl_lock   in   1            set sticky lock
//  tbl_ack    out  1            1-cycle pulse: previous-cycle write taken
//  tbl_err    out  1            1-cycle pulse: previous-cycle write rejected
//  locked     out  1            table frozen until rst
// BEHAVIOUR
//  - Index per lane x: row={x[IN_W-1],x[0]}, col=x[IN_W-2:1], idx={row,col}; out=table[idx].
//  - Reset table: IN_W=4,OUT_W=2 -> S1 rows (0 1 2 3)(2 0 1 3)(3 0 1 0)(2 1 0 3), entry row*4+col;
//    other params -> table[i]=i[OUT_W-1:0].
//  - Reset (rst=1 at edge): s0_v=0, out_valid=0, out_data=0, tbl_ack=0, tbl_err=0, locked=0,
//    table reloaded; in_ready=0 while rst high. Reset mid-stream drops all in-flight beats.
//  - Stages: S0 = input register (s0_v,s0_data); S1 = output register (out_valid,out_data).
//    s1_load = s0_v && (!out_valid || out_ready); s1 performs lookup of s0_data on s1_load.
//    in_ready = !s0_v || s1_load; beat accepted when in_valid && in_ready.
//    Accept at edge N -> out_valid visible after edge N+1; throughput 1 beat/cycle, no bubbles.
//  - out_valid && !out_ready: out_data held stable; S0 holds; in_ready=0 once S0 full.
//  - out_valid drops when consumed and no s1_load in same cycle.
//  - Table write accepted when tbl_we && !locked && !s0_v; written at that edge; tbl_ack next cycle.
//    Otherwise (locked or s0_v) tbl_err next cycle, table unchanged. Beat accepted same cycle as
//    an accepted write sees the new entry (lookup happens later, at S0->S1).
//  - tbl_lock: locked<=1 at edge; tbl_we+tbl_lock same cycle while unlocked -> write taken, then lock.
//  - tbl_we and tbl_err/tbl_ack never stall the datapath.
//  - Widths: no arithmetic; all indices exactly IN_W bits, no wrap logic needed.
// TESTING
//  1. After rst, in_data={4'b1111,4'b0001}, out_ready=1 -> out_data={2'b11,2'b10} one cycle after S0.
//  2. Lane0 sweeps 0..15 back-to-back, out_ready=1 -> lane0 out 0,2,1,0,2,1,3,3,3,2,0,1,1,0,0,3,
//     out_valid continuous, in_ready never drops.
//  3. Continuous in_valid, out_ready=0 for 5 cycles -> in_ready=0 after 2 beats accepted, out_data
//     stable; on release all beats appear in order, none lost or duplicated.
//  4. Pipeline empty, tbl_we addr=4'b0000 wdata=2'b11 -> tbl_ack next cycle; input 4'b0000 -> 2'b11.
//  5. tbl_we while s0_v=1 -> tbl_err, table unchanged; then tbl_lock pulse, tbl_we -> tbl_err,
//     locked=1 held until rst.
//  6. rst while out_valid=1 and S0 full -> out_valid=0, locked=0 next cycle; input 4'b0000 -> 2'b00.

Source files
------------

// File: rtl/sbox_lookup_pipe_if.sv
// Valid/ready stream bundle for the S-box lookup engine: input beats in, looked-up beats out.
// The engine uses the slave modport; the upstream/downstream driver uses master.
interface sbox_lookup_pipe_if #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 2,
   parameter int LANES = 2
);
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*IN_W-1:0]  in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*OUT_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/sbox_lookup_pipe.sv
// Programmable S-box lookup: one shared table applied to LANES inputs per beat,
// 2-stage valid/ready pipeline, table rewritable while the pipeline input stage is empty.
module sbox_lookup_pipe #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 2,
   parameter int LANES = 2
) (
   input  logic             clk,
   input  logic             rst,
   sbox_lookup_pipe_if.slave bus,
   input  logic             tbl_we,
   input  logic [IN_W-1:0]  tbl_addr,
   input  logic [OUT_W-1:0] tbl_wdata,
   input  logic             tbl_lock,
   output logic             tbl_ack,
   output logic             tbl_err,
   output logic             locked
);
   localparam int unsigned DEPTH = 2 ** IN_W;
   // S-DES S1, entry i at bits [2*i +: 2], entry index = row*4 + col
   localparam logic [31:0] S1_FLAT = 32'hC613_D2E4;

   logic [OUT_W-1:0]       tbl [DEPTH];
   logic                   s0_v;
   logic [LANES*IN_W-1:0]  s0_data;
   logic                   out_valid_q;
   logic [LANES*OUT_W-1:0] out_data_q;
   logic [LANES*OUT_W-1:0] lookup;
   logic                   s1_load;
   logic                   accept;
   logic                   wr_ok;
   logic [IN_W-1:0]        x;
   logic [IN_W-1:0]        idx;

   function automatic logic [OUT_W-1:0] reset_entry(input int unsigned i);
      logic [1:0] s1;
      if (IN_W == 4 && OUT_W == 2) begin
         s1 = S1_FLAT[i*2 +: 2];
         return OUT_W'(s1);
      end
      return i[OUT_W-1:0];
   endfunction

   assign s1_load       = s0_v && (!out_valid_q || bus.out_ready);
   assign bus.in_ready  = !rst && (!s0_v || s1_load);
   assign accept        = bus.in_valid && bus.in_ready;
   assign wr_ok         = tbl_we && !locked && !s0_v;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // Outer bits of each lane select the row, inner bits the column.
   always_comb begin
      lookup = '0;
      x      = '0;
      idx    = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         x   = s0_data[k*IN_W +: IN_W];
         idx = {x[IN_W-1], x[0], x[IN_W-2:1]};
         lookup[k*OUT_W +: OUT_W] = tbl[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_v        <= 1'b0;
         s0_data     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         tbl_ack     <= 1'b0;
         tbl_err     <= 1'b0;
         locked      <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tbl[i] <= reset_entry(i);
         end
      end else begin
         if (accept) begin
            s0_v    <= 1'b1;
            s0_data <= bus.in_data;
         end else if (s1_load) begin
            s0_v <= 1'b0;
         end

         if (s1_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= lookup;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         // Writes only land while S0 is empty, so a beat accepted alongside sees the new entry.
         tbl_ack <= wr_ok;
         tbl_err <= tbl_we && !wr_ok;
         if (wr_ok) begin
            tbl[tbl_addr] <= tbl_wdata;
         end
         if (tbl_lock) begin
            locked <= 1'b1;
         end
      end
   end
endmodule
